text_buffer_sequencer: RTL and testbench

//  Sequences writes of a packed character string into the text-overlay character RAM.

---
 rtl/text_buffer_sequencer_if.sv | 23 ++
 rtl/text_buffer_sequencer.sv | 112 +++++++++++
 tb/tb_text_buffer_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/text_buffer_sequencer_if.sv
// String-source handshake and character-RAM write bus of the text buffer sequencer.
// master = string source / RAM side, slave = sequencer.
interface text_buffer_sequencer_if #(
  parameter int NUM_CHAR = 13,
  parameter int AW       = 4
);
  logic [NUM_CHAR*8-1:0] i_characters;
  logic                  i_str_valid;
  logic                  o_str_ready;
  logic                  o_wr_en;
  logic [AW-1:0]         o_wr_addr;
  logic [7:0]            o_wr_data;

  modport master (
    output i_characters, i_str_valid,
    input  o_str_ready, o_wr_en, o_wr_addr, o_wr_data
  );

  modport slave (
    input  i_characters, i_str_valid,
    output o_str_ready, o_wr_en, o_wr_addr, o_wr_data
  );
endinterface

// File: rtl/text_buffer_sequencer.sv
// Writes a packed string into the text-overlay char RAM, one cell per clock,
// optionally deferred to a frame boundary; reads are gated until the buffer is whole.
module text_buffer_sequencer #(
  parameter int         COLUMNS       = 7,
  parameter int         ROWS          = 2,
  parameter int         NUM_CHAR      = 13,
  parameter int         SYNC_TO_FRAME = 1,
  parameter logic [7:0] PAD_CHAR      = 8'h20
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  text_buffer_sequencer_if.slave   bus,
  input  logic                     i_nf,
  input  logic                     i_rd_req,
  output logic                     o_rd_en,
  output logic                     o_wr_completed
);
  localparam int DEPTH = ROWS * COLUMNS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_WAIT_FRAME, ST_WRITE} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic [DEPTH-1:0][7:0]   str_q, str_d;
  logic                    wr_en_q, wr_en_d;
  logic [AW-1:0]           wr_addr_q, wr_addr_d;
  logic [7:0]              wr_data_q, wr_data_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    hs, last;

  assign hs   = bus.i_str_valid & ready_q;
  assign last = (cnt_q == AW'(DEPTH - 1));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      str_q     <= {DEPTH{PAD_CHAR}};
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      str_q     <= str_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  // An i_nf coincident with the handshake is never seen: it is sampled in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR:      if (last) state_d = ST_IDLE;
      ST_IDLE:       if (hs)   state_d = (SYNC_TO_FRAME != 0) ? ST_WAIT_FRAME : ST_WRITE;
      ST_WAIT_FRAME: if (i_nf) state_d = ST_WRITE;
      ST_WRITE:      if (last) state_d = ST_IDLE;
      default:       state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    cnt_d     = '0;
    str_d     = str_q;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    ready_d   = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = PAD_CHAR;
        cnt_d     = last ? '0 : cnt_q + AW'(1);
      end
      ST_IDLE: begin
        ready_d = ~hs;
        done_d  = ~hs;
        // Latch already padded so WRITE is a plain indexed read.
        if (hs) begin
          str_d = {DEPTH{PAD_CHAR}};
          for (int i = 0; i < NUM_CHAR; i++)
            if (bus.i_characters[(NUM_CHAR-1-i)*8 +: 8] != 8'h00)
              str_d[i] = bus.i_characters[(NUM_CHAR-1-i)*8 +: 8];
        end
      end
      ST_WRITE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = str_q[cnt_q];
        cnt_d     = last ? '0 : cnt_q + AW'(1);
      end
      default: ;
    endcase
  end

  assign bus.o_str_ready = ready_q;
  assign bus.o_wr_en     = wr_en_q;
  assign bus.o_wr_addr   = wr_addr_q;
  assign bus.o_wr_data   = wr_data_q;
  assign o_wr_completed  = done_q;
  assign o_rd_en         = i_rd_req & done_q;
endmodule

// File: tb/tb_text_buffer_sequencer.sv
// Directed bench: u0 starts writing right after the handshake, u1 waits for i_nf.
module tb_text_buffer_sequencer;
  logic clk = 1'b0;
  logic rst_n, nf, rd_req;
  logic rd_en0, done0, rd_en1, done1;
  int npass = 0, nfail = 0, ntotal = 0;
  logic [7:0] exp_b [14];

  always #5 clk = ~clk;

  text_buffer_sequencer_if #(.NUM_CHAR(13), .AW(4)) b0 ();
  text_buffer_sequencer_if #(.NUM_CHAR(13), .AW(4)) b1 ();

  text_buffer_sequencer #(.COLUMNS(7), .ROWS(2), .NUM_CHAR(13), .SYNC_TO_FRAME(0), .PAD_CHAR(8'h20)) u0 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(b0.slave), .i_nf(nf), .i_rd_req(rd_req),
    .o_rd_en(rd_en0), .o_wr_completed(done0));

  text_buffer_sequencer #(.COLUMNS(7), .ROWS(2), .NUM_CHAR(13), .SYNC_TO_FRAME(1), .PAD_CHAR(8'h20)) u1 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(b1.slave), .i_nf(nf), .i_rd_req(rd_req),
    .o_rd_en(rd_en1), .o_wr_completed(done1));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_spaces;
    for (int i = 0; i < 14; i++) exp_b[i] = 8'h20;
  endtask

  // 14 back-to-back writes matching exp_b, then the completion cycle.
  task automatic collect(input bit sel, input string tag);
    for (int k = 0; k < 14; k++) begin
      tick;
      chk($sformatf("%s en k=%0d", tag, k),   sel ? b1.o_wr_en   : b0.o_wr_en,   1);
      chk($sformatf("%s addr k=%0d", tag, k), sel ? b1.o_wr_addr : b0.o_wr_addr, k);
      chk($sformatf("%s data k=%0d", tag, k), sel ? b1.o_wr_data : b0.o_wr_data, exp_b[k]);
      chk($sformatf("%s done k=%0d", tag, k), sel ? done1 : done0, 0);
      chk($sformatf("%s rd_en k=%0d", tag, k), sel ? rd_en1 : rd_en0, 0);
    end
    tick;
    chk({tag, " end en"},    sel ? b1.o_wr_en     : b0.o_wr_en,     0);
    chk({tag, " end addr"},  sel ? b1.o_wr_addr   : b0.o_wr_addr,   0);
    chk({tag, " end data"},  sel ? b1.o_wr_data   : b0.o_wr_data,   0);
    chk({tag, " end done"},  sel ? done1 : done0, 1);
    chk({tag, " end ready"}, sel ? b1.o_str_ready : b0.o_str_ready, 1);
    chk({tag, " end rd_en"}, sel ? rd_en1 : rd_en0, rd_req);
  endtask

  initial begin
    int en_seen, rd_seen;
    rst_n = 1'b0; nf = 1'b0; rd_req = 1'b1;
    b0.i_characters = '0; b0.i_str_valid = 1'b0;
    b1.i_characters = '0; b1.i_str_valid = 1'b0;
    tick; tick;

    // Reset state
    chk("rst en",    b0.o_wr_en, 0);
    chk("rst addr",  b0.o_wr_addr, 0);
    chk("rst data",  b0.o_wr_data, 0);
    chk("rst done",  done0, 0);
    chk("rst ready", b0.o_str_ready, 0);
    chk("rst rd_en", rd_en0, 0);

    // 1: power-up clear
    rst_n = 1'b1;
    set_spaces();
    collect(0, "clear");
    chk("clear u1 done", done1, 1);
    rd_req = 1'b0; #1;
    chk("rd_en follows req low", rd_en0, 0);
    rd_req = 1'b1; #1;
    chk("rd_en follows req high", rd_en0, 1);

    // 2: immediate write of "Hello, world!"
    b0.i_characters = "Hello, world!";
    b0.i_str_valid = 1'b1;
    tick;
    b0.i_str_valid = 1'b0;
    chk("hs ready drop", b0.o_str_ready, 0);
    chk("hs done drop",  done0, 0);
    chk("hs rd_en",      rd_en0, 0);
    exp_b = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
              8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h20};
    collect(0, "hello");

    // 3: frame-synchronised write, i_nf with the handshake is ignored
    b1.i_characters = "Hello, world!";
    b1.i_str_valid = 1'b1;
    nf = 1'b1;
    tick;
    b1.i_str_valid = 1'b0;
    nf = 1'b0;
    en_seen = 0; rd_seen = 0;
    for (int c = 0; c < 100; c++) begin
      tick;
      if (b1.o_wr_en) en_seen++;
      if (rd_en1) rd_seen++;
    end
    chk("wait no writes", en_seen, 0);
    chk("wait no rd_en",  rd_seen, 0);
    chk("wait ready",     b1.o_str_ready, 0);
    nf = 1'b1;
    tick;
    nf = 1'b0;
    chk("nf edge no write yet", b1.o_wr_en, 0);
    collect(1, "sync");

    // 4: valid held across a busy write
    exp_b = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
              8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h20};
    b0.i_characters = "Hello, world!";
    b0.i_str_valid = 1'b1;
    tick;
    b0.i_characters = "Hello, hello!";
    collect(0, "held A");
    tick;
    b0.i_str_valid = 1'b0;
    chk("held B hs ready", b0.o_str_ready, 0);
    exp_b = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
              8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h20};
    collect(0, "held B");

    // 5: NUL bytes (index 3 and the last character) become spaces
    b0.i_characters = 104'h41_42_43_00_45_46_47_48_49_4A_4B_4C_00;
    b0.i_str_valid = 1'b1;
    tick;
    b0.i_str_valid = 1'b0;
    exp_b = '{8'h41, 8'h42, 8'h43, 8'h20, 8'h45, 8'h46, 8'h47,
              8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h20, 8'h20};
    collect(0, "nul");

    // 6: reset in the middle of a write
    b0.i_characters = "Hello, world!";
    b0.i_str_valid = 1'b1;
    tick;
    b0.i_str_valid = 1'b0;
    for (int c = 0; c < 6; c++) tick;
    chk("mid k=5 addr", b0.o_wr_addr, 5);
    chk("mid k=5 data", b0.o_wr_data, 8'h2C);
    rst_n = 1'b0;
    tick;
    chk("mid rst en",    b0.o_wr_en, 0);
    chk("mid rst addr",  b0.o_wr_addr, 0);
    chk("mid rst done",  done0, 0);
    chk("mid rst ready", b0.o_str_ready, 0);
    rst_n = 1'b1;
    set_spaces();
    collect(0, "reclear");

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
